// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer.
//   shift_op_t  : request opcode (none / logical left / logical right / arithmetic right)
//   seq_state_t : sequencer FSM states
package shift_pkg;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step.
// Ports:
//   acc_i     : current accumulator value
//   op_i      : shift operation
//   acc_o     : accumulator after one 1-bit step
//   out_bit_o : bit shifted out by this step (0 for SH_NONE)
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc_i,
  input  shift_op_t        op_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             out_bit_o
);

  always_comb begin
    acc_o     = acc_i;
    out_bit_o = 1'b0;
    case (op_i)
      SH_LSL: begin
        acc_o     = {acc_i[WIDTH-2:0], 1'b0};
        out_bit_o = acc_i[WIDTH-1];
      end
      SH_LSR: begin
        acc_o     = {1'b0, acc_i[WIDTH-1:1]};
        out_bit_o = acc_i[0];
      end
      SH_ASR: begin
        acc_o     = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
        out_bit_o = acc_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request, shifts its operand one bit per
// cycle for req_amt cycles, then presents the result until consumed.
// Build option: define SHIFT_SEQ_CARRY_EN to add the carry_out output
// (last bit shifted out; 0 for bypass requests).
// Ports:
//   clk, rst_n                 : clock (rising edge), synchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_data, req_op, req_amt  : operand, opcode (00 none, 01 LSL, 10 LSR, 11 ASR), distance
//   rsp_valid/rsp_ready        : response handshake
//   rsp_data                   : result
//   busy                       : high whenever not IDLE
//   carry_out                  : (SHIFT_SEQ_CARRY_EN only) last shifted-out bit
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [1:0]       req_op,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef SHIFT_SEQ_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] count_q, count_d;
  shift_op_t        op_q, op_d;
  logic [WIDTH-1:0] step_acc;
  shift_op_t        req_op_e;

`ifdef SHIFT_SEQ_CARRY_EN
  logic carry_q, carry_d;
  logic step_bit;
`else
  logic step_bit_unused;
`endif

  assign req_op_e = shift_op_t'(req_op);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i     (acc_q),
    .op_i      (op_q),
    .acc_o     (step_acc),
`ifdef SHIFT_SEQ_CARRY_EN
    .out_bit_o (step_bit)
`else
    .out_bit_o (step_bit_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= SH_NONE;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      op_q    <= op_d;
`ifdef SHIFT_SEQ_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    op_d      = op_q;
`ifdef SHIFT_SEQ_CARRY_EN
    carry_d   = carry_q;
`endif
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          acc_d   = req_data;
          op_d    = req_op_e;
          count_d = req_amt;
`ifdef SHIFT_SEQ_CARRY_EN
          carry_d = 1'b0;
`endif
          // Zero-distance and no-op requests skip SHIFT entirely.
          state_d = (req_op_e == SH_NONE || req_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = step_acc;
        count_d = count_q - AMT_W'(1);
`ifdef SHIFT_SEQ_CARRY_EN
        carry_d = step_bit;
`endif
        // Exit on the 1->0 step so the maximum distance never wraps.
        if (count_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data = acc_q;
`ifdef SHIFT_SEQ_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_data = '0;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_amt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        busy;
`ifdef SHIFT_SEQ_CARRY_EN
  logic        carry_out;
`endif

  shift_sequencer #(
    .WIDTH (16),
    .AMT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_op    (req_op),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    .carry_out (carry_out)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        carry;
    int unsigned cyc;   // negedge cycle of first rsp_valid; 0 = not checked
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected response: got 0x%0h expected none", rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, " data"}, rsp_data, mon_e.data);
`ifdef SHIFT_SEQ_CARRY_EN
        chk({mon_e.name, " carry"}, carry_out, mon_e.carry);
`endif
        if (mon_e.cyc != 0) chk({mon_e.name, " latency"}, cyc, mon_e.cyc);
      end
    end
  end

  task automatic drive(input string name, input logic [1:0] op, input logic [15:0] data,
                       input logic [3:0] amt);
    int unsigned waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) chk({name, " ready timeout"}, req_ready, 1);
    req_valid = 1'b1;
    req_data  = data;
    req_op    = op;
    req_amt   = amt;
  endtask

  // Scramble inputs right after acceptance: the in-flight operation must ignore them.
  task automatic release_req(input logic [1:0] op, input logic [15:0] data, input logic [3:0] amt);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = ~data;
    req_op    = ~op;
    req_amt   = ~amt;
  endtask

  task automatic send(input string name, input logic [1:0] op, input logic [15:0] data,
                      input logic [3:0] amt, input logic [15:0] exp_data,
                      input logic exp_carry, input int unsigned lat);
    exp_t e;
    drive(name, op, data, amt);
    e.name  = name;
    e.data  = exp_data;
    e.carry = exp_carry;
    e.cyc   = (lat == 0) ? 0 : cyc + lat;
    sb.push_back(e);
    release_req(op, data, amt);
  endtask

  task automatic drain();
    int unsigned waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " req_ready"}, req_ready, 1);
    chk({name, " rsp_valid"}, rsp_valid, 0);
    chk({name, " rsp_data"}, rsp_data, 16'h0000);
    chk({name, " busy"}, busy, 0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk({name, " carry"}, carry_out, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int unsigned waited;
    int unsigned stale;

    // Reset with a request offered: must not be captured.
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_data  = 16'hBEEF;
    req_op    = SH_LSL;
    req_amt   = 4'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    req_valid = 1'b0;
    rst_n     = 1'b1;

    // Directed vectors: op, data, amt, expected data, expected carry, latency
    send("lsl1x4",    SH_LSL,  16'h0001, 4'd4,  16'h0010, 1'b0, 5);
    send("asr8000x15",SH_ASR,  16'h8000, 4'd15, 16'hFFFF, 1'b0, 16);
    send("lsr8001x1", SH_LSR,  16'h8001, 4'd1,  16'h4000, 1'b1, 2);
    send("nop1234",   SH_NONE, 16'h1234, 4'd7,  16'h1234, 1'b0, 1);
    send("lslABCDx0", SH_LSL,  16'hABCD, 4'd0,  16'hABCD, 1'b0, 1);
    send("lslFFFFx15",SH_LSL,  16'hFFFF, 4'd15, 16'h8000, 1'b1, 16);
    send("lsrFFFFx15",SH_LSR,  16'hFFFF, 4'd15, 16'h0001, 1'b1, 16);
    send("asr4000x3", SH_ASR,  16'h4000, 4'd3,  16'h0800, 1'b0, 4);
    send("lsl8001x1", SH_LSL,  16'h8001, 4'd1,  16'h0002, 1'b1, 2);
    send("asrF0F0x4", SH_ASR,  16'hF0F0, 4'd4,  16'hFF0F, 1'b0, 5);
    send("asr7FFFx15",SH_ASR,  16'h7FFF, 4'd15, 16'h0000, 1'b1, 16);
    send("nopx15",    SH_NONE, 16'h5A5A, 4'd15, 16'h5A5A, 1'b0, 1);
    drain();

    // Back-pressure in DONE with a competing request held valid.
    @(negedge clk);
    rsp_ready = 1'b0;
    send("stall", SH_LSR, 16'h1234, 4'd2, 16'h048D, 1'b0, 0);
    waited = 0;
    while (!rsp_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("stall rsp_valid", rsp_valid, 1);
    req_valid = 1'b1;
    req_data  = 16'h0F0F;
    req_op    = SH_LSL;
    req_amt   = 4'd1;
    repeat (3) begin
      @(negedge clk);
      chk("stall rsp_data", rsp_data, 16'h048D);
      chk("stall req_ready", req_ready, 0);
      chk("stall rsp_valid", rsp_valid, 1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    e.name  = "post-stall";
    e.data  = 16'h1E1E;
    e.carry = 1'b0;
    e.cyc   = cyc + 3;   // IDLE next edge, accept the edge after, one step
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("post-stall idle req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 16'hFFFF;
    drain();

    // Reset during SHIFT after three steps.
    drive("rst-abort", SH_LSL, 16'h00FF, 4'd8);
    release_req(SH_LSL, 16'h00FF, 4'd8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_data  = 16'h5555;
    req_op    = SH_LSL;
    req_amt   = 4'd1;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    chk_idle("mid-shift reset");
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("no stale response", stale, 0);

    // Recovery after abort.
    send("lsr00F0x5", SH_LSR, 16'h00F0, 4'd5, 16'h0007, 1'b1, 6);
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width.
REQ-002 SHALL have parameter AMT_W, default 4, shift-amount width (max amount 2**AMT_W-1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_data  input  WIDTH  operand.
REQ-008 SHALL have port req_op  input  2  00 none, 01 LSL, 10 LSR, 11 ASR.
REQ-009 SHALL have port req_amt  input  AMT_W  shift distance.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-012 SHALL have port rsp_data  output  WIDTH  result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; req_ready = (state==IDLE), rsp_valid = (state==DONE).
REQ-015 IDLE: on req_valid&&req_ready SHALL capture req_data into acc, op and amt into count; next state DONE if op==00 or amt==0, else SHIFT.
REQ-016 SHIFT: each cycle SHALL apply one 1-bit step to acc per op, decrement count, and go to DONE when count transitions 1->0.
REQ-017 Step: LSL -> {acc[W-2:0],0}; LSR -> {0,acc[W-1:1]}; ASR -> {acc[W-1],acc[W-1:1]}; all results truncated to WIDTH.
REQ-018 Latency: first rsp_valid cycle SHALL be amt+1 cycles after the accept cycle for shifting ops, 1 cycle for bypass (op 00 or amt 0).
REQ-019 DONE: rsp_data SHALL equal acc and hold stable while rsp_ready is low; on rsp_ready, next state IDLE.
REQ-020 req_ready SHALL be low in SHIFT and DONE; requests offered then are not captured; no back-to-back acceptance in the rsp handshake cycle.
REQ-021 req_op/req_amt/req_data changes after acceptance SHALL NOT affect the operation in flight.
REQ-022 amt = 2**AMT_W-1 SHALL be supported without counter wrap; LSL/LSR by 15 on WIDTH 16 leaves at most one original bit.

Reset
REQ-023 rst_n low at a rising edge SHALL force state IDLE, acc 0, count 0, aborting any operation, including mid-SHIFT or DONE.
REQ-024 After reset: req_ready 1, rsp_valid 0, rsp_data 0, busy 0, carry_out 0.
REQ-025 A request offered during the cycle rst_n is low SHALL NOT be accepted.

Configuration
REQ-026 With macro SHIFT_SEQ_CARRY_EN defined, SHALL add output carry_out (1 bit): cleared on accept, updated each step to the bit shifted out (acc[W-1] for LSL, acc[0] for LSR/ASR), held through DONE; 0 for bypass.
REQ-027 Without SHIFT_SEQ_CARRY_EN, carry_out port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package shift_pkg SHALL hold enum shift_op_t (SH_NONE, SH_LSL, SH_LSR, SH_ASR, 2-bit) and FSM state enum seq_state_t.
REQ-029 Single-bit step logic SHALL be a combinational sub-module shift_step (inputs acc, op; outputs next acc, shifted-out bit), instantiated once.

Verification
REQ-030 LSL 0x0001 amt 4, rsp_ready=1 -> rsp_valid 5 cycles after accept, rsp_data 0x0010, carry_out 0.
REQ-031 ASR 0x8000 amt 15 -> rsp_data 0xFFFF after 16 cycles; LSR 0x8001 amt 1 -> 0x4000, carry_out 1.
REQ-032 op 00 amt 7 data 0x1234, and LSL amt 0 data 0xABCD -> rsp_valid 1 cycle after accept, data unchanged.
REQ-033 rsp_ready low 3 cycles in DONE with req_valid high -> rsp_data stable, req_ready 0, no capture; accepts only after return to IDLE.
REQ-034 rst_n low for one cycle during SHIFT (LSL 0x00FF amt 8, after 3 steps) -> next cycle IDLE, rsp_valid 0, rsp_data 0, req_ready 1, no stale response.
